ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage fed directly by the ID/EX pipeline register; drives the EX/MEM fields.
- Single-cycle ALU for ALUop 00/01/10. Iterative 32-step shift-add multiplier for ALUop 11; low 32 bits of the product only.
- Registers its own outputs, acting as the EX/MEM register.
- Raises stall_o toward IF/ID/ID-EX while a multiply is in flight.

Parameters:
- XLEN, 32, datapath width (only 32 is supported/verified)
- CNT_W, 5, multiplier iteration counter width (log2 XLEN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  ID/EX slot holds a real instruction
- flush_i  in  1  synchronous kill of current/in-flight EX work
- mem_to_reg_i  in  2  writeback select, passed through
- ALUop_i  in  2  00 add, 01 sub/compare, 10 funct-decoded, 11 multiply
- memWrite_i, memRead_i, regWrite_i, ALUSrc_i  in  1 each  controls
- funct7_i  in  1  instr[30]
- funct3_i  in  3  instr[14:12]
- pc_4_i, rd1_i, rd2_i, imm_i  in  XLEN each  operands
- writeReg_i  in  5  destination register
- stall_o  out  1  upstream must hold its registers (combinational)
- valid_o, regWrite_o, memWrite_o, memRead_o, zero_o  out  1 each
- mem_to_reg_o  out  2
- writeReg_o  out  5
- alu_result_o, rd2_o, pc_4_o  out  XLEN each

Behaviour:
- Reset (rst=1, async): all outputs 0, FSM to IDLE, counter and accumulator 0. Reset mid-multiply aborts it; no result is produced.
- Operand B = ALUSrc_i ? imm_i : rd2_i. Operand A = rd1_i.
- ALUop 00: A+B.
- ALUop 01: A-B.
- zero_o = (result == 0), registered with the result, valid for every op.
- ALUop 10, by funct3:
  - 000: A-B if funct7_i && !ALUSrc_i, else A+B
  - 001: sll
  - 010: slt (signed)
  - 011: sltu
  - 100: xor
  - 101: sra if funct7_i, else srl
  - 110: or
  - 111: and
  - Shift amount is B[4:0]. Arithmetic wraps mod 2^32.
- Single-cycle op (IDLE, valid_i=1, ALUop!=11, flush_i=0):
  - Next edge loads all outputs from inputs/result.
  - valid_o=1, rd2_o=rd2_i (store data), stall_o=0.
- Bubble (valid_i=0 or flush_i=1 in IDLE):
  - Next edge: valid_o=0, regWrite_o=0, memWrite_o=0, memRead_o=0.
  - All other outputs hold.
- FSM states: IDLE, MUL.
- IDLE -> MUL on start = valid_i && ALUop_i==11 && !flush_i.
  - stall_o=1 in the start cycle (combinational).
  - At the edge: capture mcand=A, mplier=rd2_i (ALUSrc ignored), acc=0, cnt=0, plus all pass-through fields.
  - Outputs take bubble values.
- MUL, each cycle:
  - If mplier[0], acc += mcand.
  - mcand <<= 1, mplier >>= 1, cnt++.
  - stall_o=1.
- MUL exit: when cnt==31, at that edge write outputs with the final acc value (including that cycle's add) and valid_o=1, then go to IDLE.
- Multiply issued in cycle T:
  - stall_o high for cycles T..T+32.
  - Result visible after edge ending T+32.
  - Next instruction accepted in cycle T+33.
- Outputs during MUL keep bubble values (valid_o=0, write enables 0).
- flush_i in MUL: next edge aborts to IDLE with bubble outputs; stall_o drops in the following cycle.
- flush_i together with a start in IDLE: flush wins, no multiply starts.
- Inputs are ignored while in MUL. Upstream holds them stable via stall_o.

Optional Feature:
- Macro: EX_MUL_EARLY_TERM_EN
- Defined: MUL also exits when the post-shift mplier is 0.
  - Exit occurs at the edge where (mplier>>1)==0 or cnt==31; result written that edge.
  - Latency = max(1, index of the highest set bit of rd2 + 1) cycles after start.
  - rd2=0 exits after 1 cycle with result 0.
- Undefined: fixed 32 iterations as above.

Test Plan:
- ALUop10 funct3=000 funct7=1 ALUSrc=0, rd1=5, rd2=7 -> next edge: alu_result=0xFFFFFFFE, zero=0, valid_o=1, stall_o never high.
- ALUop10 funct3=101 funct7=1 ALUSrc=1, rd1=0x80000000, imm=4 -> alu_result=0xF8000000. ALUop01 rd1=rd2=9 -> result 0, zero=1.
- ALUop11 rd1=7, rd2=6, start cycle T, macro off -> stall_o high T..T+32, valid_o=0 until edge ending T+32, then alu_result=42, valid_o=1. With EX_MUL_EARLY_TERM_EN: result after edge ending T+3, stall high T..T+3.
- ALUop11 rd1=0xFFFFFFFF, rd2=3 -> alu_result=0xFFFFFFFD. rd1=0x12345678, rd2=0 -> alu_result=0, zero=1.
- Flush in cycle T+10 of a multiply -> edge ending T+10 returns to IDLE, valid_o=0, no write enables, stall_o=0 at T+11. Flush together with a start -> no stall at all.
- rst asserted asynchronously at T+5 of a multiply -> outputs 0 immediately. After release, an add (rd1=1, imm=2, ALUSrc=1, ALUop00) gives 3 next edge.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage / EX-MEM register: single-cycle ALU plus an iterative shift-add multiplier.
// Optional EX_MUL_EARLY_TERM_EN: multiplier exits as soon as the remaining multiplier bits are zero.
module ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [1:0]      mem_to_reg_i,
    input  logic [1:0]      ALUop_i,
    input  logic            memWrite_i,
    input  logic            memRead_i,
    input  logic            regWrite_i,
    input  logic            ALUSrc_i,
    input  logic            funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] pc_4_i,
    input  logic [XLEN-1:0] rd1_i,
    input  logic [XLEN-1:0] rd2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      writeReg_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic            regWrite_o,
    output logic            memWrite_o,
    output logic            memRead_o,
    output logic            zero_o,
    output logic [1:0]      mem_to_reg_o,
    output logic [4:0]      writeReg_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] rd2_o,
    output logic [XLEN-1:0] pc_4_o
);
    typedef enum logic {IDLE, MUL} state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   op_b, alu_res;
    logic [XLEN-1:0]   mcand, mplier, acc, acc_add;
    logic [CNT_W-1:0]  cnt;
    logic              start, single, mul_last;

    // pass-through fields captured at multiply start
    logic [4:0]        p_wr;
    logic [1:0]        p_m2r;
    logic              p_rw, p_mw, p_mr;
    logic [XLEN-1:0]   p_pc4, p_rd2;

    assign op_b    = ALUSrc_i ? imm_i : rd2_i;
    assign start   = (state == IDLE) && valid_i && (ALUop_i == 2'b11) && !flush_i;
    assign single  = (state == IDLE) && valid_i && (ALUop_i != 2'b11) && !flush_i;
    assign stall_o = (state == MUL) || start;
    assign acc_add = mplier[0] ? acc + mcand : acc;

`ifdef EX_MUL_EARLY_TERM_EN
    assign mul_last = (cnt == {CNT_W{1'b1}}) || ((mplier >> 1) == '0);
`else
    assign mul_last = (cnt == {CNT_W{1'b1}});
`endif

    always_comb begin
        alu_res = '0;
        case (ALUop_i)
            2'b00: alu_res = rd1_i + op_b;
            2'b01: alu_res = rd1_i - op_b;
            2'b10: begin
                case (funct3_i)
                    3'b000: alu_res = (funct7_i && !ALUSrc_i) ? rd1_i - op_b : rd1_i + op_b;
                    3'b001: alu_res = rd1_i << op_b[4:0];
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(rd1_i) < $signed(op_b)};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, rd1_i < op_b};
                    3'b100: alu_res = rd1_i ^ op_b;
                    3'b101: alu_res = funct7_i ? XLEN'($signed(rd1_i) >>> op_b[4:0])
                                               : rd1_i >> op_b[4:0];
                    3'b110: alu_res = rd1_i | op_b;
                    default: alu_res = rd1_i & op_b;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = MUL;
            MUL:  if (flush_i || mul_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p_wr   <= '0;
            p_m2r  <= '0;
            p_rw   <= 1'b0;
            p_mw   <= 1'b0;
            p_mr   <= 1'b0;
            p_pc4  <= '0;
            p_rd2  <= '0;
        end else if (start) begin
            mcand  <= rd1_i;
            mplier <= rd2_i;
            acc    <= '0;
            cnt    <= '0;
            p_wr   <= writeReg_i;
            p_m2r  <= mem_to_reg_i;
            p_rw   <= regWrite_i;
            p_mw   <= memWrite_i;
            p_mr   <= memRead_i;
            p_pc4  <= pc_4_i;
            p_rd2  <= rd2_i;
        end else if (state == MUL) begin
            acc    <= acc_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // EX/MEM register: a bubble clears only valid and the write enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o      <= 1'b0;
            regWrite_o   <= 1'b0;
            memWrite_o   <= 1'b0;
            memRead_o    <= 1'b0;
            zero_o       <= 1'b0;
            mem_to_reg_o <= '0;
            writeReg_o   <= '0;
            alu_result_o <= '0;
            rd2_o        <= '0;
            pc_4_o       <= '0;
        end else if (single) begin
            valid_o      <= 1'b1;
            regWrite_o   <= regWrite_i;
            memWrite_o   <= memWrite_i;
            memRead_o    <= memRead_i;
            zero_o       <= (alu_res == '0);
            mem_to_reg_o <= mem_to_reg_i;
            writeReg_o   <= writeReg_i;
            alu_result_o <= alu_res;
            rd2_o        <= rd2_i;
            pc_4_o       <= pc_4_i;
        end else if (state == MUL && !flush_i && mul_last) begin
            valid_o      <= 1'b1;
            regWrite_o   <= p_rw;
            memWrite_o   <= p_mw;
            memRead_o    <= p_mr;
            zero_o       <= (acc_add == '0);
            mem_to_reg_o <= p_m2r;
            writeReg_o   <= p_wr;
            alu_result_o <= acc_add;
            rd2_o        <= p_rd2;
            pc_4_o       <= p_pc4;
        end else begin
            valid_o      <= 1'b0;
            regWrite_o   <= 1'b0;
            memWrite_o   <= 1'b0;
            memRead_o    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes reference results, negedge monitor pops on valid_o.
module tb_ex_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        valid_i, flush_i, memWrite_i, memRead_i, regWrite_i, ALUSrc_i, funct7_i;
    logic [1:0]  mem_to_reg_i, ALUop_i;
    logic [2:0]  funct3_i;
    logic [31:0] pc_4_i, rd1_i, rd2_i, imm_i;
    logic [4:0]  writeReg_i;
    logic        stall_o, valid_o, regWrite_o, memWrite_o, memRead_o, zero_o;
    logic [1:0]  mem_to_reg_o;
    logic [4:0]  writeReg_o;
    logic [31:0] alu_result_o, rd2_o, pc_4_o;

    ex_stage #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
        .mem_to_reg_i(mem_to_reg_i), .ALUop_i(ALUop_i), .memWrite_i(memWrite_i),
        .memRead_i(memRead_i), .regWrite_i(regWrite_i), .ALUSrc_i(ALUSrc_i),
        .funct7_i(funct7_i), .funct3_i(funct3_i), .pc_4_i(pc_4_i), .rd1_i(rd1_i),
        .rd2_i(rd2_i), .imm_i(imm_i), .writeReg_i(writeReg_i), .stall_o(stall_o),
        .valid_o(valid_o), .regWrite_o(regWrite_o), .memWrite_o(memWrite_o),
        .memRead_o(memRead_o), .zero_o(zero_o), .mem_to_reg_o(mem_to_reg_o),
        .writeReg_o(writeReg_o), .alu_result_o(alu_result_o), .rd2_o(rd2_o),
        .pc_4_o(pc_4_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op; logic f7; logic [2:0] f3; logic src;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0] wr; logic rw, mw, mr; logic [1:0] m2r;
    } instr_t;

    logic [106:0] expq[$];
    int total = 0, bad = 0;
    logic [31:0] last_res = '0;

    function automatic logic [31:0] model(instr_t t);
        logic [31:0] a, b;
        a = t.rd1;
        b = t.src ? t.imm : t.rd2;
        case (t.op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd3: return a * t.rd2;
            default: case (t.f3)
                3'd0: return (t.f7 && !t.src) ? a - b : a + b;
                3'd1: return a << b[4:0];
                3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: return (a < b) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: return t.f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'd6: return a | b;
                default: return a & b;
            endcase
        endcase
    endfunction

    function automatic int mul_lat(logic [31:0] r);
`ifdef EX_MUL_EARLY_TERM_EN
        int h = 0;
        for (int i = 0; i < 32; i++) if (r[i]) h = i + 1;
        return (h == 0) ? 1 : h;
`else
        return (r == r) ? 32 : 32;
`endif
    endfunction

    task automatic check(input string name, input logic [106:0] got, input logic [106:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(instr_t t, logic v, logic f);
        valid_i = v; flush_i = f; ALUop_i = t.op; funct7_i = t.f7; funct3_i = t.f3;
        ALUSrc_i = t.src; rd1_i = t.rd1; rd2_i = t.rd2; imm_i = t.imm; pc_4_i = t.pc4;
        writeReg_i = t.wr; regWrite_i = t.rw; memWrite_i = t.mw; memRead_i = t.mr;
        mem_to_reg_i = t.m2r;
    endtask

    // Issue one instruction in the current cycle; for a multiply, wait for its result.
    task automatic issue(instr_t t);
        logic [31:0] r;
        int lat, k;
        r = model(t);
        drive(t, 1'b1, 1'b0);
        #1;
        check("stall_issue", 107'(stall_o), 107'(t.op == 2'd3));
        expq.push_back({r, r == 32'd0, t.wr, t.rw, t.mw, t.mr, t.m2r, t.rd2, t.pc4});
        @(posedge clk); #1;
        if (t.op == 2'd3) begin
            lat = mul_lat(t.rd2);
            k = 1;
            while (!valid_o && k < 40) begin
                check("stall_mul", 107'(stall_o), 107'd1);
                @(posedge clk); #1;
                k++;
            end
            check("mul_latency", 107'(k), 107'(lat + 1));
        end
    endtask

    task automatic bubble(logic f);
        instr_t t;
        t = '{op: 2'($urandom), f7: 1'b1, f3: 3'($urandom), src: 1'b0, rd1: $urandom,
              rd2: $urandom, imm: $urandom, pc4: $urandom, wr: 5'($urandom),
              rw: 1'b1, mw: 1'b1, mr: 1'b1, m2r: 2'($urandom)};
        if (!f && t.op == 2'd3) t.op = 2'd0;
        drive(t, f, f);
        #1;
        check("stall_bubble", 107'(stall_o), 107'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t mk(logic [1:0] op, logic f7, logic [2:0] f3, logic src,
                                  logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm);
        instr_t t;
        t = '{op: op, f7: f7, f3: f3, src: src, rd1: rd1, rd2: rd2, imm: imm,
              pc4: $urandom, wr: 5'($urandom), rw: 1'($urandom), mw: 1'($urandom),
              mr: 1'($urandom), m2r: 2'($urandom)};
        return t;
    endfunction

    // Monitor: every valid_o sample is a fresh result; bubbles keep the last result.
    always @(negedge clk) begin
        if (rst) begin
            last_res = '0;
        end else if (valid_o) begin
            if (expq.size() == 0) begin
                check("unexpected_valid", 107'(alu_result_o), 107'hDEAD);
            end else begin
                check("result", {alu_result_o, zero_o, writeReg_o, regWrite_o, memWrite_o,
                                 memRead_o, mem_to_reg_o, rd2_o, pc_4_o}, expq.pop_front());
            end
            last_res = alu_result_o;
        end else begin
            check("bubble_hold", {alu_result_o, regWrite_o, memWrite_o, memRead_o},
                  {last_res, 3'b000});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        drive(mk(2'd0, 1'b0, 3'd0, 1'b0, 0, 0, 0), 1'b0, 1'b0);
        #12;
        check("reset_state", {valid_o, regWrite_o, memWrite_o, memRead_o, zero_o, mem_to_reg_o,
                              writeReg_o, alu_result_o, rd2_o, pc_4_o, stall_o}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(mk(2'd2, 1'b1, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0));
        issue(mk(2'd2, 1'b1, 3'd5, 1'b1, 32'h8000_0000, $urandom, 32'd4));
        issue(mk(2'd1, 1'b0, 3'd0, 1'b0, 32'd9, 32'd9, 32'd3));
        issue(mk(2'd3, 1'b0, 3'd0, 1'b1, 32'd7, 32'd6, 32'd99));
        issue(mk(2'd3, 1'b0, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0));
        issue(mk(2'd3, 1'b0, 3'd0, 1'b0, 32'h1234_5678, 32'd0, 32'd0));
        bubble(1'b0);

        // flush in cycle T+10 of a multiply
        drive(mk(2'd3, 1'b0, 3'd0, 1'b0, 32'd11, 32'h8000_0003, 0), 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        #1;
        check("stall_flush_cycle", 107'(stall_o), 107'd1);
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        #1;
        check("flush_abort", {stall_o, valid_o, regWrite_o, memWrite_o, memRead_o}, '0);
        for (int i = 0; i < 35; i++) begin @(posedge clk); #1; end

        // flush together with a start
        drive(mk(2'd3, 1'b0, 3'd0, 1'b0, 32'd3, 32'd5, 0), 1'b1, 1'b1);
        #1;
        check("flush_start_stall", 107'(stall_o), 107'd0);
        @(posedge clk); #1;
        check("flush_start_out", {stall_o, valid_o}, '0);
        bubble(1'b0);

        // asynchronous reset in the middle of a multiply
        drive(mk(2'd3, 1'b0, 3'd0, 1'b0, 32'd13, 32'h8000_0001, 0), 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin @(posedge clk); #1; end
        valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_midmul", {valid_o, regWrite_o, memWrite_o, memRead_o, zero_o, mem_to_reg_o,
                               writeReg_o, alu_result_o, rd2_o, pc_4_o, stall_o}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(mk(2'd0, 1'b0, 3'd0, 1'b1, 32'd1, $urandom, 32'd2));
        bubble(1'b0);
        for (int i = 0; i < 35; i++) begin @(posedge clk); #1; end

        // randomized mix
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 7))
                0: bubble(1'b0);
                1: bubble(1'b1);
                2: begin
                    t = mk(2'd3, 1'($urandom), 3'($urandom), 1'($urandom), pick(), pick(), pick());
                    issue(t);
                end
                default: begin
                    t = mk(2'($urandom_range(0, 2)), 1'($urandom), 3'($urandom), 1'($urandom),
                           pick(), pick(), pick());
                    issue(t);
                end
            endcase
        end
        bubble(1'b0);
        bubble(1'b0);
        check("queue_empty", 107'(expq.size()), 107'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
